crypto_seq_ctrl: RTL and testbench

CRYPTO_SEQ_CTRL -- requirements
Module: crypto_seq_ctrl

---
 rtl/crypto_seq_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_crypto_seq_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crypto_seq_ctrl.sv
// crypto_seq_ctrl: micro-sequencer that fetches byte opcodes from memory and runs ENC/DEC rounds.
// Optional DEC datapath: define CRYPTO_SEQ_CTRL_DEC_EN to enable opcode 0x70.
//
// state   | meaning
// IDLE    | after reset; host may load program, start begins at PC=0
// FETCH   | reading opcode at PC
// OPERAND | reading operand word at PC for LDA/LDB/STC
// EXEC    | ENC/DEC rounds, one per cycle
// STORE   | writing reg_c to operand address
// HALT    | stopped by HALT (halted) or illegal opcode (err)
module crypto_seq_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int ROUNDS = 1,
  parameter int OFFSET = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] reg_a,
  output logic [DATA_W-1:0] reg_b,
  output logic [DATA_W-1:0] reg_c,
  output logic              busy,
  output logic              halted,
  output logic              err
);

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_LDA  = 8'h20;
  localparam logic [7:0] OP_LDB  = 8'h30;
  localparam logic [7:0] OP_STC  = 8'h40;
  localparam logic [7:0] OP_ENC  = 8'h60;
`ifdef CRYPTO_SEQ_CTRL_DEC_EN
  localparam logic [7:0] OP_DEC  = 8'h70;
`endif
  localparam logic [7:0] OP_HALT = 8'hFF;

  localparam logic [DATA_W-1:0] OFF      = DATA_W'(OFFSET);
  localparam logic [3:0]        RND_INIT = 4'(ROUNDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_OPERAND,
    S_EXEC,
    S_STORE,
    S_HALT
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [7:0]        op;
  logic [DATA_W-1:0] c_work;
  logic [DATA_W-1:0] round_out;
  logic [3:0]        rnd_cnt;
  logic              req_r;
  logic              we_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;

  logic              acked;
  logic              host_sel;
  logic [ADDR_W-1:0] pc_inc;

  assign acked    = req_r && mem_ack;
  assign pc_inc   = pc + ADDR_W'(1);
  assign host_sel = ((state == S_IDLE) || (state == S_HALT)) && host_we;

  // host loads bypass the registered request path so a write takes one cycle
  assign mem_req   = host_sel | req_r;
  assign mem_we    = host_sel | we_r;
  assign mem_addr  = host_sel ? host_addr : addr_r;
  assign mem_wdata = host_sel ? host_wdata : wdata_r;

  function automatic logic [DATA_W-1:0] enc_round(input logic [DATA_W-1:0] c,
                                                  input logic [DATA_W-1:0] k);
    logic [DATA_W-1:0] t;
    t = (c << 1) + OFF;
    return t ^ k;
  endfunction

`ifdef CRYPTO_SEQ_CTRL_DEC_EN
  function automatic logic [DATA_W-1:0] dec_round(input logic [DATA_W-1:0] c,
                                                  input logic [DATA_W-1:0] k);
    logic [DATA_W-1:0] t;
    t = (c ^ k) - OFF;
    return t >> 1;
  endfunction
`endif

  always_comb begin
    round_out = enc_round(c_work, reg_b);
`ifdef CRYPTO_SEQ_CTRL_DEC_EN
    if (op == OP_DEC) round_out = dec_round(c_work, reg_b);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      pc      <= '0;
      op      <= '0;
      c_work  <= '0;
      rnd_cnt <= '0;
      reg_a   <= '0;
      reg_b   <= '0;
      reg_c   <= '0;
      req_r   <= 1'b0;
      we_r    <= 1'b0;
      addr_r  <= '0;
      wdata_r <= '0;
      busy    <= 1'b0;
      halted  <= 1'b0;
      err     <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_HALT: begin
          if (start && !host_we) begin
            state  <= S_FETCH;
            busy   <= 1'b1;
            halted <= 1'b0;
            err    <= 1'b0;
            pc     <= '0;
            req_r  <= 1'b1;
            we_r   <= 1'b0;
            addr_r <= '0;
          end
        end

        S_FETCH: begin
          if (acked) begin
            op <= mem_rdata[7:0];
            pc <= pc_inc;
            case (mem_rdata[7:0])
              OP_NOP: addr_r <= pc_inc;
              OP_LDA, OP_LDB, OP_STC: begin
                state  <= S_OPERAND;
                addr_r <= pc_inc;
              end
              OP_ENC: begin
                state   <= S_EXEC;
                req_r   <= 1'b0;
                c_work  <= reg_a;
                rnd_cnt <= RND_INIT;
              end
`ifdef CRYPTO_SEQ_CTRL_DEC_EN
              OP_DEC: begin
                state   <= S_EXEC;
                req_r   <= 1'b0;
                c_work  <= reg_a;
                rnd_cnt <= RND_INIT;
              end
`endif
              OP_HALT: begin
                state  <= S_HALT;
                req_r  <= 1'b0;
                busy   <= 1'b0;
                halted <= 1'b1;
              end
              default: begin
                state <= S_HALT;
                req_r <= 1'b0;
                busy  <= 1'b0;
                err   <= 1'b1;
              end
            endcase
          end
        end

        S_OPERAND: begin
          if (acked) begin
            pc <= pc_inc;
            case (op)
              OP_LDA: begin
                reg_a  <= mem_rdata;
                state  <= S_FETCH;
                addr_r <= pc_inc;
              end
              OP_LDB: begin
                reg_b  <= mem_rdata;
                state  <= S_FETCH;
                addr_r <= pc_inc;
              end
              default: begin
                state   <= S_STORE;
                we_r    <= 1'b1;
                addr_r  <= ADDR_W'(mem_rdata);
                wdata_r <= reg_c;
              end
            endcase
          end
        end

        S_EXEC: begin
          c_work  <= round_out;
          rnd_cnt <= rnd_cnt - 4'd1;
          if (rnd_cnt == 4'd1) begin
            reg_c  <= round_out;
            state  <= S_FETCH;
            req_r  <= 1'b1;
            addr_r <= pc;
          end
        end

        S_STORE: begin
          if (acked) begin
            state   <= S_FETCH;
            we_r    <= 1'b0;
            addr_r  <= pc;
            wdata_r <= '0;
          end
        end

        default: begin
          state <= S_IDLE;
          req_r <= 1'b0;
          we_r  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_crypto_seq_ctrl.sv
// Bench for crypto_seq_ctrl: two instances (ROUNDS=1 and ROUNDS=2) share stimulus, each with its own memory.
// Expected results come from a program interpreter working on plain integers.
module tb_crypto_seq_ctrl;

`ifdef CRYPTO_SEQ_CTRL_DEC_EN
  localparam bit DEC_ON = 1'b1;
`else
  localparam bit DEC_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1, start = 1'b0, host_we = 1'b0;
  logic [7:0] host_addr = '0, host_wdata = '0;
  logic       host_phase = 1'b1, stray_ack = 1'b0, mon_en = 1'b0, exec_clr = 1'b0;
  int         ack_mode = 1;

  logic [1:0]      busy_v, halted_v, err_v;
  logic [1:0][7:0] rega_v, regb_v, regc_v, exec_v;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  for (genvar k = 0; k < 2; k++) begin : g_dut
    logic        mem_req, mem_we, mem_ack, busy, halted, err;
    logic [7:0]  mem_addr, mem_wdata, mem_rdata, reg_a, reg_b, reg_c;
    logic [7:0]  mem [256];
    int          cnt = 0, dly = 1, run_len = 0, max_exec = 0;
    logic        pend = 1'b0;
    logic [17:0] saved = '0;

    crypto_seq_ctrl #(.DATA_W(8), .ADDR_W(8), .ROUNDS(k + 1), .OFFSET(5)) u_dut (
      .clk(clk), .rst(rst), .start(start), .host_we(host_we),
      .host_addr(host_addr), .host_wdata(host_wdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .reg_a(reg_a), .reg_b(reg_b), .reg_c(reg_c),
      .busy(busy), .halted(halted), .err(err)
    );

    assign mem_ack   = (mem_req && (host_phase || cnt >= dly)) || stray_ack;
    assign mem_rdata = mem[mem_addr];
    assign busy_v[k]   = busy;
    assign halted_v[k] = halted;
    assign err_v[k]    = err;
    assign rega_v[k]   = reg_a;
    assign regb_v[k]   = reg_b;
    assign regc_v[k]   = reg_c;
    assign exec_v[k]   = 8'(max_exec);

    // memory: acks after a per-transaction delay, writes on acked write requests
    always @(posedge clk) begin
      if (mem_req && mem_ack && mem_we) mem[mem_addr] <= mem_wdata;
      if (!mem_req || mem_ack) begin
        cnt <= 0;
        dly <= (ack_mode < 0) ? int'($urandom_range(5, 0)) : ack_mode;
      end else begin
        cnt <= cnt + 1;
      end
    end

    always @(negedge clk) begin
      if (pend && mon_en)
        chk($sformatf("req_stable%0d", k), {mem_req, mem_we, mem_addr, mem_wdata}, saved);
      pend  <= mon_en && mem_req && !mem_ack && !host_phase;
      saved <= {mem_req, mem_we, mem_addr, mem_wdata};
      if (exec_clr) begin
        run_len  <= 0;
        max_exec <= 0;
      end else if (busy && !mem_req) begin
        run_len <= run_len + 1;
      end else begin
        if (run_len > max_exec) max_exec <= run_len;
        run_len <= 0;
      end
    end
  end

  // reference model: program interpreter over its own memory image
  logic [7:0] rmem [2][256];
  logic [7:0] ma [2], mb [2], mc [2];
  logic       mhalt [2], merr [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      ma[k] = 0; mb[k] = 0; mc[k] = 0; mhalt[k] = 0; merr[k] = 0;
    end
  endtask

  task automatic model_run(input int k);
    int pc, t;
    logic [7:0] op;
    pc = 0; mhalt[k] = 0; merr[k] = 0;
    for (int s = 0; s < 400; s++) begin
      op = rmem[k][pc];
      pc = (pc + 1) % 256;
      if (op == 8'h00) continue;
      else if (op == 8'h20) begin ma[k] = rmem[k][pc]; pc = (pc + 1) % 256; end
      else if (op == 8'h30) begin mb[k] = rmem[k][pc]; pc = (pc + 1) % 256; end
      else if (op == 8'h40) begin rmem[k][rmem[k][pc]] = mc[k]; pc = (pc + 1) % 256; end
      else if (op == 8'h60) begin
        t = int'(ma[k]);
        for (int r = 0; r <= k; r++) t = ((t * 2 + 5) % 256) ^ int'(mb[k]);
        mc[k] = 8'(t);
      end else if (op == 8'h70 && DEC_ON) begin
        t = int'(ma[k]);
        for (int r = 0; r <= k; r++) t = (((t ^ int'(mb[k])) - 5 + 256) % 256) / 2;
        mc[k] = 8'(t);
      end else if (op == 8'hFF) begin mhalt[k] = 1; return; end
      else begin merr[k] = 1; return; end
    end
  endtask

  task automatic host_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    host_we = 1'b1; host_addr = a; host_wdata = d;
    rmem[0][a] = d; rmem[1][a] = d;
    #1 chk("host_path", {g_dut[0].mem_req, g_dut[0].mem_we, g_dut[0].mem_addr, g_dut[0].mem_wdata},
           {2'b11, a, d});
  endtask

  task automatic load_prog(input logic [7:0] p [$]);
    foreach (p[i]) host_write(8'(i), p[i]);
    @(negedge clk);
    host_we = 1'b0;
  endtask

  task automatic reset_dut();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic run_prog(input int mode);
    ack_mode = mode;
    @(negedge clk); host_phase = 1'b0; exec_clr = 1'b1; mon_en = 1'b1;
    @(negedge clk); exec_clr = 1'b0; start = 1'b1;
    // second start and a host write land while busy and must be ignored
    @(negedge clk); host_we = 1'b1; host_addr = 8'hF0; host_wdata = 8'($urandom);
    @(negedge clk); start = 1'b0; host_we = 1'b0;
    for (int i = 0; i < 3000 && busy_v != 2'b00; i++) @(negedge clk);
    chk("run_done", busy_v, 0);
    host_phase = 1'b1;
    model_run(0);
    model_run(1);
  endtask

  task automatic check_final(input int k);
    chk($sformatf("reg_a%0d", k), rega_v[k], ma[k]);
    chk($sformatf("reg_b%0d", k), regb_v[k], mb[k]);
    chk($sformatf("reg_c%0d", k), regc_v[k], mc[k]);
    chk($sformatf("halted%0d", k), halted_v[k], mhalt[k]);
    chk($sformatf("err%0d", k), err_v[k], merr[k]);
  endtask

  task automatic mem_check();
    int d0, d1;
    d0 = 0; d1 = 0;
    for (int i = 0; i < 256; i++) begin
      if (g_dut[0].mem[i] !== rmem[0][i]) d0++;
      if (g_dut[1].mem[i] !== rmem[1][i]) d1++;
    end
    chk("mem0_diffs", d0, 0);
    chk("mem1_diffs", d1, 0);
  endtask

  function automatic bit is_legal(input logic [7:0] b);
    return b inside {8'h00, 8'h20, 8'h30, 8'h40, 8'h60, 8'h70, 8'hFF};
  endfunction

  logic [7:0] prog [$];
  logic [7:0] b;
  bit hit;

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_flags", {busy_v, halted_v, err_v}, 0);
    chk("rst_regs0", {rega_v[0], regb_v[0], regc_v[0]}, 0);
    chk("rst_regs1", {rega_v[1], regb_v[1], regc_v[1]}, 0);
    chk("rst_mem_out", {g_dut[0].mem_req, g_dut[0].mem_we, g_dut[0].mem_addr, g_dut[0].mem_wdata}, 0);
    rst = 1'b0;

    prog = {};
    for (int i = 0; i < 256; i++) prog.push_back(8'h00);
    load_prog(prog);

    // basic ENC program, ack one cycle after request
    load_prog('{8'h20, 8'h12, 8'h30, 8'h0F, 8'h60, 8'hFF});
    run_prog(1);
    chk("enc_r1_c", regc_v[0], 8'h26);
    chk("enc_r1_halt", {halted_v[0], err_v[0]}, 2'b10);
    chk("enc_r2_c", regc_v[1], 8'h5E);
    chk("exec_len_r1", exec_v[0], 1);
    chk("exec_len_r2", exec_v[1], 2);
    check_final(0); check_final(1);

    // DEC program: result depends on build option
    reset_dut();
    load_prog('{8'h20, 8'h26, 8'h30, 8'h0F, 8'h70, 8'hFF});
    run_prog(1);
    chk("dec_c", regc_v[0], DEC_ON ? 8'h12 : 8'h00);
    chk("dec_flags", {halted_v[0], err_v[0]}, DEC_ON ? 2'b10 : 2'b01);
    check_final(0); check_final(1);

    // random ack delay
    reset_dut();
    load_prog('{8'h20, 8'h12, 8'h30, 8'h0F, 8'h60, 8'hFF});
    run_prog(-1);
    chk("rand_ack_c", regc_v[0], 8'h26);
    chk("rand_ack_halt", {halted_v[0], err_v[0]}, 2'b10);
    check_final(0); check_final(1);

    // store path
    load_prog('{8'h20, 8'hAA, 8'h30, 8'h55, 8'h60, 8'h40, 8'h80, 8'hFF});
    run_prog(2);
    chk("stc_mem80", g_dut[0].mem[8'h80], 8'h0C);
    check_final(0); check_final(1);
    mem_check();

    // start together with host_we from HALT: write wins, start dropped
    @(negedge clk);
    start = 1'b1; host_we = 1'b1; host_addr = 8'h90; host_wdata = 8'h3C;
    rmem[0][8'h90] = 8'h3C; rmem[1][8'h90] = 8'h3C;
    @(negedge clk);
    start = 1'b0; host_we = 1'b0;
    chk("start_dropped_busy", busy_v, 0);
    chk("start_dropped_halt", halted_v, 2'b11);
    mem_check();

    // reset during OPERAND, stray acks afterwards, then clean re-run
    reset_dut();
    load_prog('{8'h20, 8'h12, 8'h30, 8'h0F, 8'h60, 8'hFF});
    ack_mode = 3;
    @(negedge clk); host_phase = 1'b0; mon_en = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (g_dut[0].mem_req && g_dut[0].mem_addr == 8'h01 && busy_v[0]) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("operand_seen", hit, 1);
    mon_en = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_flags", {busy_v, halted_v, err_v}, 0);
    chk("rst_mid_regs0", {rega_v[0], regb_v[0], regc_v[0]}, 0);
    chk("rst_mid_mem0", {g_dut[0].mem_req, g_dut[0].mem_we, g_dut[0].mem_addr, g_dut[0].mem_wdata}, 0);
    stray_ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stray_ack_ignored", {busy_v, g_dut[0].mem_req, g_dut[1].mem_req}, 0);
    end
    stray_ack = 1'b0;
    model_reset();
    run_prog(1);
    chk("rerun_c", regc_v[0], 8'h26);
    chk("rerun_halt", {halted_v[0], err_v[0]}, 2'b10);
    check_final(0); check_final(1);

    // random programs; registers persist across runs
    for (int n = 0; n < 25; n++) begin
      prog = {};
      for (int i = 0; i < int'($urandom_range(8, 1)); i++) begin
        case ($urandom_range(11, 0))
          0:       prog.push_back(8'h00);
          1, 2:    begin prog.push_back(8'h20); prog.push_back(8'($urandom)); end
          3, 4:    begin prog.push_back(8'h30); prog.push_back(8'($urandom)); end
          5, 6:    begin prog.push_back(8'h40); prog.push_back(8'(8'h80 + $urandom_range(8'h6F, 0))); end
          7, 8, 9: prog.push_back(8'h60);
          10:      prog.push_back(8'h70);
          default: begin
            b = 8'($urandom);
            while (is_legal(b)) b = 8'($urandom);
            prog.push_back(b);
          end
        endcase
      end
      prog.push_back(8'hFF);
      load_prog(prog);
      run_prog(($urandom_range(3, 0) == 0) ? -1 : int'($urandom_range(5, 0)));
      check_final(0); check_final(1);
    end
    mem_check();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
